matmul_feeder: RTL

MATMUL_FEEDER -- requirements
Module: matmul_feeder

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/mm_row_buf.sv | 53 +++++
 rtl/matmul_feeder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared defaults and FSM state encoding for the matmul feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int DIM_DEFAULT     = 8;
    localparam int EW_DEFAULT      = 8;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mm_row_buf.sv
`default_nettype none
// ============================================================================
// Module      : mm_row_buf
// Description : DEPTH x WIDTH row register file, one synchronous write port,
//               one combinational read port, asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_row_buf
    import matmul_pkg::*;
#(
    parameter  int DEPTH = DIM_DEFAULT,
    parameter  int WIDTH = DIM_DEFAULT * EW_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] rows [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        logic [WIDTH-1:0] row_d;
        logic [WIDTH-1:0] row_q;

        // Next value: replace the row only when it is the write target.
        always_comb begin
            row_d = row_q;
            if (we_i && (waddr_i == AW'(i))) begin
                row_d = wdata_i;
            end
        end

        // Row storage, cleared asynchronously.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                row_q <= '0;
            end else begin
                row_q <= row_d;
            end
        end

        assign rows[i] = row_q;
    end

    assign rdata_o = rows[raddr_i];

endmodule
`default_nettype wire

// File: rtl/matmul_feeder.sv
`default_nettype none
// ============================================================================
// Module      : matmul_feeder
// Description : Streams A[r][k] / B[k] operand beats into an external row
//               engine, one row of C per pass, and captures each result row.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_feeder
    import matmul_pkg::*;
#(
    parameter  int DIM     = DIM_DEFAULT,
    parameter  int EW      = EW_DEFAULT,
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int IDX_W   = $clog2(DIM),
    localparam int ROW_W   = DIM * EW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             ld_a_i,
    input  logic             ld_b_i,
    input  logic [IDX_W-1:0] ld_row_i,
    input  logic [ROW_W-1:0] ld_data_i,
    output logic             mm_en_o,
    output logic             mm_valid_o,
    output logic [EW-1:0]    mm_din1_o,
    output logic [ROW_W-1:0] mm_din2_o,
    input  logic             mm_valid_i,
    input  logic [ROW_W-1:0] mm_result_i,
    input  logic [IDX_W-1:0] rd_row_i,
    output logic [ROW_W-1:0] rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state_d, state_q;
    logic [IDX_W-1:0] r_d, r_q;
    logic [IDX_W-1:0] k_d, k_q;
    logic [TMO_W-1:0] tmo_d, tmo_q;
    logic             done_d, done_q;
    logic             error_d, error_q;

    logic             active;
    logic [ROW_W-1:0] a_row;
    logic [ROW_W-1:0] b_row;

    // Operand A is read by the current row, B by the current beat.
    mm_row_buf #(.DEPTH(DIM), .WIDTH(ROW_W)) u_a_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ld_a_i && !busy_o),
        .waddr_i (ld_row_i),
        .wdata_i (ld_data_i),
        .raddr_i (r_q),
        .rdata_o (a_row)
    );

    mm_row_buf #(.DEPTH(DIM), .WIDTH(ROW_W)) u_b_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ld_b_i && !busy_o),
        .waddr_i (ld_row_i),
        .wdata_i (ld_data_i),
        .raddr_i (k_q),
        .rdata_o (b_row)
    );

    // The engine's result lags its valid by one cycle, hence capture in CAPTURE.
    mm_row_buf #(.DEPTH(DIM), .WIDTH(ROW_W)) u_c_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (state_q == ST_CAPTURE),
        .waddr_i (r_q),
        .wdata_i (mm_result_i),
        .raddr_i (rd_row_i),
        .rdata_o (rd_data_o)
    );

    // Next-state and counter logic for the issue/wait/capture sequence.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    r_d     = '0;
                    k_d     = '0;
                    error_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (k_q == LAST_IDX) begin
                    state_d = ST_WAIT;
                    k_d     = '0;
                    tmo_d   = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (mm_valid_i) begin
                    state_d = ST_CAPTURE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    r_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ISSUE;
                    r_d     = r_q + 1'b1;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, indices, timeout counter and status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            k_q     <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Outputs decode registered state only, so reset zeroes them immediately.
    assign active     = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                        (state_q == ST_CAPTURE) || (state_q == ST_NEXT);
    assign busy_o     = active;
    assign mm_en_o    = active;
    assign mm_valid_o = (state_q == ST_ISSUE);
    assign mm_din1_o  = mm_valid_o ? a_row[k_q*EW +: EW] : '0;
    assign mm_din2_o  = mm_valid_o ? b_row : '0;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule
`default_nettype wire
